// File: rtl/mha_pkg.sv
// Shared types and constants for the MHA multiplier path.
// Holds the arbiter FSM encoding and datapath widths.
package mha_pkg;

  localparam int DATA_W  = 16;
  localparam int MUL_LAT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RSP
  } arb_st_e;

endpackage

// File: rtl/multiplier_16.sv
// Q2.13 signed multiplier with a start/busy protocol.
// Result valid MUL_LAT cycles after the start cycle.
module multiplier_16
  import mha_pkg::*;
(
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VLD,
  input  logic [DATA_W-1:0] I_M1,
  input  logic [DATA_W-1:0] I_M2,
  output logic              O_BUSY,
  output logic              O_VLD,
  output logic [DATA_W-1:0] O_PRODUCT
);

  logic signed [DATA_W-1:0] m1_q;
  logic signed [DATA_W-1:0] m2_q;
  logic [2:0]               cnt;
  logic signed [31:0]       full;
  logic [DATA_W-1:0]        q_res;

  // Full-precision product and its Q2.13 rescale (sign + bits 27:13)
  always_comb begin
    full  = m1_q * m2_q;
    q_res = {full[31], 15'(full >> 13)};
  end

  // Capture operands on start, count down, then present the result
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      m1_q      <= '0;
      m2_q      <= '0;
      cnt       <= '0;
      O_BUSY    <= 1'b0;
      O_VLD     <= 1'b0;
      O_PRODUCT <= '0;
    end else begin
      O_VLD <= 1'b0;
      if (I_VLD && !O_BUSY) begin
        m1_q   <= I_M1;
        m2_q   <= I_M2;
        cnt    <= 3'(MUL_LAT - 1);
        O_BUSY <= 1'b1;
      end else if (O_BUSY) begin
        if (cnt == 3'd1) begin
          O_BUSY    <= 1'b0;
          O_VLD     <= 1'b1;
          O_PRODUCT <= q_res;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority encoder over a request vector.
// Searches upward from I_PTR with wrap; lowest offset wins.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    I_VLD,
  input  logic [ID_W-1:0] I_PTR,
  output logic [N-1:0]    O_GNT,
  output logic [ID_W-1:0] O_IDX,
  output logic            O_ANY
);

  int j;

  // Walk offsets high to low so the nearest requester is kept last
  always_comb begin
    O_GNT = '0;
    O_IDX = '0;
    O_ANY = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(I_PTR) + k) % N;
      if (|(I_VLD & (N'(1) << j))) begin
        O_GNT = N'(1) << j;
        O_IDX = ID_W'(j);
        O_ANY = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one multiplier_16 among N_REQ lanes.
// One transaction in flight; product returned as a tagged pulse.
module mul_arbiter
  import mha_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                    I_CLK,
  input  logic                    I_RST_N,
  input  logic [N_REQ-1:0]        I_REQ_VLD,
  input  logic [DATA_W*N_REQ-1:0] I_REQ_M1,
  input  logic [DATA_W*N_REQ-1:0] I_REQ_M2,
  output logic [N_REQ-1:0]        O_REQ_RDY,
  output logic [N_REQ-1:0]        O_RSP_VLD,
  output logic [ID_W-1:0]         O_RSP_ID,
  output logic [DATA_W-1:0]       O_RSP_PRODUCT,
  output logic                    O_ARB_BUSY
);

  arb_st_e           st;
  arb_st_e           st_nx;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nx;
  logic [DATA_W-1:0] lat_m1;
  logic [DATA_W-1:0] lat_m2;
  logic [ID_W-1:0]   lat_id;
  logic [DATA_W-1:0] sel_m1;
  logic [DATA_W-1:0] sel_m2;
  logic [N_REQ-1:0]  rsp_vld;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_prod;
  logic [N_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic              take;
  logic              mul_vld;
  logic              mul_busy;
  logic              mul_ovld;
  logic [DATA_W-1:0] mul_prod;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .I_VLD (I_REQ_VLD),
    .I_PTR (ptr),
    .O_GNT (pick_gnt),
    .O_IDX (pick_idx),
    .O_ANY (pick_any)
  );

  multiplier_16 u_mul (
    .I_CLK     (I_CLK),
    .I_RST_N   (I_RST_N),
    .I_VLD     (mul_vld),
    .I_M1      (lat_m1),
    .I_M2      (lat_m2),
    .O_BUSY    (mul_busy),
    .O_VLD     (mul_ovld),
    .O_PRODUCT (mul_prod)
  );

  // Operand mux for the picked lane and the advanced pointer
  always_comb begin
    sel_m1 = '0;
    sel_m2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_m1 = I_REQ_M1[i*DATA_W +: DATA_W];
        sel_m2 = I_REQ_M2[i*DATA_W +: DATA_W];
      end
    end
    if (int'(pick_idx) == N_REQ - 1) ptr_nx = '0;
    else                             ptr_nx = pick_idx + 1'b1;
  end

  // Next state, grant and multiplier start; RSP may grant like IDLE
  always_comb begin
    st_nx     = st;
    O_REQ_RDY = '0;
    take      = 1'b0;
    mul_vld   = 1'b0;
    unique case (st)
      IDLE, RSP: begin
        st_nx = IDLE;
        if (I_RST_N && !mul_busy && pick_any) begin
          O_REQ_RDY = pick_gnt;
          take      = 1'b1;
          st_nx     = ISSUE;
        end
      end
      ISSUE: begin
        mul_vld = !mul_busy;
        st_nx   = WAIT;
      end
      WAIT: begin
        if (mul_ovld) st_nx = RSP;
      end
      default: st_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) st <= IDLE;
    else          st <= st_nx;
  end

  // Operand latch, pointer advance and response capture
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      ptr      <= '0;
      lat_m1   <= '0;
      lat_m2   <= '0;
      lat_id   <= '0;
      rsp_vld  <= '0;
      rsp_id   <= '0;
      rsp_prod <= '0;
    end else begin
      rsp_vld <= '0;
      if (take) begin
        lat_m1 <= sel_m1;
        lat_m2 <= sel_m2;
        lat_id <= pick_idx;
        ptr    <= ptr_nx;
      end
      if (st == WAIT && mul_ovld) begin
        rsp_vld  <= N_REQ'(1) << lat_id;
        rsp_id   <= lat_id;
        rsp_prod <= mul_prod;
      end
    end
  end

  assign O_RSP_VLD     = rsp_vld;
  assign O_RSP_ID      = rsp_id;
  assign O_RSP_PRODUCT = rsp_prod;
  assign O_ARB_BUSY    = (st != IDLE);

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

- Round-robin arbiter and sequencer that shares one `multiplier_16` among `N_REQ` requesters, such as attention score/weight lanes.
- Accepts one operand pair at a time over a per-requester valid/ready handshake, then drives the multiplier's start/busy protocol.
- Routes each 16-bit fixed-point product back to its owner as a one-cycle response pulse with requester ID.
- Sits between the MHA compute lanes and the single shared multiplier instance.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default 2: requester ID width; must be ≥ clog2(N_REQ).
- `I_CLK` in 1: single clock; all state updates on the rising edge.
- `I_RST_N` in 1: asynchronous, active-low reset.
- `I_REQ_VLD` in N_REQ: per-requester operand valid.
- `I_REQ_M1` in 16*N_REQ: multiplicands; requester i uses bits [16i+15:16i].
- `I_REQ_M2` in 16*N_REQ: multipliers, same slicing as `I_REQ_M1`.
- `O_REQ_RDY` out N_REQ: grant/accept, at most one bit high; transfer occurs when VLD&RDY.
- `O_RSP_VLD` out N_REQ: one-cycle product-valid pulse to the owning requester.
- `O_RSP_ID` out ID_W: owner of the current or last response.
- `O_RSP_PRODUCT` out 16: product; held until the next response.
- `O_ARB_BUSY` out 1: high whenever FSM ≠ IDLE.

## Operation
- The FSM has four states; reset state is IDLE.
- **IDLE**
  - Active when the multiplier's busy is low.
  - Selects grant g = first requester with VLD=1, searching from pointer PTR upward with wrap modulo N_REQ.
  - `O_REQ_RDY[g]` is combinational, high this cycle only.
  - At the edge: latch M1/M2 slice g and g into internal regs; PTR ← (g+1) mod N_REQ; go to ISSUE.
  - No VLD: stay in IDLE; PTR unchanged.
- **ISSUE**: drive multiplier `I_VLD`=1 with the latched operands for exactly one cycle, then go to WAIT.
- **WAIT**: `I_VLD`=0; stay until the multiplier's `O_VLD`=1.
  - At that edge: register the product into `O_RSP_PRODUCT` and g into `O_RSP_ID`.
  - Set `O_RSP_VLD` = onehot(g) for the next cycle; go to RSP.
- **RSP**: response pulse is visible; return to IDLE.
  - RSP also acts as IDLE: it may grant in the same cycle, because multiplier busy is already low.
- Requester rules:
  - A requester must hold VLD and operands stable until RDY.
  - Dropping VLD before grant withdraws the request with no side effects.
  - Responses have no backpressure; requesters must sample the pulse.
- Arithmetic: no arithmetic in the arbiter. The product is the multiplier's output unchanged: Q2.13 format, sign bit plus bits [27:13] of the 32-bit internal result.
- Reset mid-operation: all registers clear asynchronously and the multiplier resets on the same `I_RST_N`. An in-flight transaction is discarded and no response is issued.
- Reset values: `O_REQ_RDY`=0, `O_RSP_VLD`=0, `O_RSP_ID`=0, `O_RSP_PRODUCT`=0, `O_ARB_BUSY`=0, PTR=0, state=IDLE.

## Timing
- Handshake in cycle A; ISSUE in A+1, which is multiplier start.
- Multiplier `O_VLD` arrives in A+5 (4 cycles after start); `O_RSP_VLD` is high in A+6.
- Request-to-response latency: 6 cycles.
- Grant-to-grant cadence: 6 cycles under continuous load. The next grant can occur in A+6, concurrent with the response pulse.
- Multiplier `I_VLD` is never asserted while multiplier busy is high. The ISSUE-state guard ensures this; a violation is an assertion failure.
- Exactly one `O_RSP_VLD` pulse per accepted request, in request order. Only one request is ever in flight.

## Structure
- Shared package `mha_pkg`:
  - FSM state encoding: IDLE, ISSUE, WAIT, RSP.
  - `MUL_LAT` = 4.
  - `DATA_W` = 16.
- Sub-module `rr_pick`: combinational round-robin priority encoder over `I_REQ_VLD` and PTR, outputting a one-hot grant and its index.
- `multiplier_16` is instantiated inside `mul_arbiter`.

## Test plan
1. Single request, req0, M1=0x2000, M2=0x2000 (1.0×1.0) → `O_REQ_RDY[0]` in cycle A; `O_RSP_VLD`=0001 in A+6; ID=0; product 0x2000.
2. Negative operand, req2, M1=0x2000, M2=0xE000 (1.0×−1.0) → ID=2, product 0xE000; a second request 0x2000×0x1000 returns 0x1000.
3. All four VLD held continuously from reset → grants in order 0,1,2,3,0 at 6-cycle spacing; each response ID matches; no starvation.
4. Requests from req1 and req3 only, with PTR=2 → req3 granted first, then req1 (wrap-around).
5. `I_RST_N` pulsed low in WAIT (A+3) → all outputs 0 immediately; no `O_RSP_VLD` pulse after release; the next request completes normally with a 6-cycle latency.
6. Req0 raises VLD, then drops it while req1 is in flight → req0 never granted, `O_RSP_VLD` only for req1; `O_ARB_BUSY` low in idle gaps.
